// File: rtl/register_file_param_if.sv
// Write, dual-read and clear-handshake bundle for register_file_param.
interface register_file_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic [ADDR_W-1:0]     rd_addr0;
  logic [ADDR_W-1:0]     rd_addr1;
  logic [DATA_W-1:0]     rd_data0;
  logic [DATA_W-1:0]     rd_data1;
  logic                  clr_req;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr0, rd_addr1, clr_req,
    input  rd_data0, rd_data1, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr0, rd_addr1, clr_req,
    output rd_data0, rd_data1, clr_busy, clr_done
  );
endinterface

// File: rtl/register_file_param.sv
// Byte-enabled register file with two combinational read ports and a sequential clear sweep.
// Optional REGFILE_WR_BYPASS_EN forwards an accepted write onto matching read ports in the same cycle.
//
// state | meaning
// IDLE  | normal operation, writes accepted
// CLEAR | sweeping entries 0..DEPTH-1 to zero, writes dropped
module register_file_param #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic                  clk,
  input logic                  reset_n,
  register_file_param_if.slave bus
);
  localparam int                NB      = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              clr_busy_q;
  logic              clr_done_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_ok;
  logic [DATA_W-1:0] wr_mask;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;

  assign wr_ok = bus.wr_en && !clr_busy_q && ({1'b0, bus.wr_addr} < DEPTH_C) && (|bus.wr_be);

  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < NB; k++) wr_mask[8*k +: 8] = {8{bus.wr_be[k]}};
  end

  // Out-of-range addresses match no entry and therefore read as zero.
  always_comb begin
    wr_old = '0;
    rd0    = '0;
    rd1    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wr_addr  == ADDR_W'(i)) wr_old = mem[i];
      if (bus.rd_addr0 == ADDR_W'(i)) rd0    = mem[i];
      if (bus.rd_addr1 == ADDR_W'(i)) rd1    = mem[i];
    end
    wr_merged = (wr_old & ~wr_mask) | (bus.wr_data & wr_mask);
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_ok && (bus.rd_addr0 == bus.wr_addr)) rd0 = wr_merged;
    if (wr_ok && (bus.rd_addr1 == bus.wr_addr)) rd1 = wr_merged;
`endif
  end

  assign bus.rd_data0 = rd0;
  assign bus.rd_data1 = rd1;
  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ok && (bus.wr_addr == ADDR_W'(i))) mem[i] <= wr_merged;
        else if ((state == CLEAR) && (clr_ptr == ADDR_W'(i))) mem[i] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clr_ptr    <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      clr_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_C) begin
            state      <= IDLE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: a DEPTH=16 instance for the main checks, DEPTH=12 for range checks.
module tb_register_file_param;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_mis;

  register_file_param_if #(.DATA_W(32), .ADDR_W(4)) b   ();
  register_file_param_if #(.DATA_W(32), .ADDR_W(4)) b12 ();

  register_file_param #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(b)
  );
  register_file_param #(.DATA_W(32), .DEPTH(12), .ADDR_W(4)) u_dut12 (
    .clk(clk), .reset_n(reset_n), .bus(b12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr16(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    b.wr_en   = 1'b1;
    b.wr_addr = a;
    b.wr_data = d;
    b.wr_be   = be;
    tick();
    b.wr_en   = 1'b0;
    b.wr_be   = '0;
  endtask

  function automatic logic [31:0] fillv(input int i);
    return 32'hC0DE_0000 + 32'(i) + 32'd1;
  endfunction

  int          busy_cycles;
  int          done_cycles;
  logic [31:0] acc;

  initial begin
    n_cmp = 0;
    n_mis = 0;
    reset_n = 1'b1;
    b.wr_en = 0;  b.wr_addr = '0;  b.wr_data = '0;  b.wr_be = '0;
    b.rd_addr0 = '0;  b.rd_addr1 = '0;  b.clr_req = 0;
    b12.wr_en = 0;  b12.wr_addr = '0;  b12.wr_data = '0;  b12.wr_be = '0;
    b12.rd_addr0 = '0;  b12.rd_addr1 = '0;  b12.clr_req = 0;

    #2 reset_n = 1'b0;
    #1;
    chk("rst_busy", 32'(b.clr_busy), 32'd0);
    chk("rst_done", 32'(b.clr_done), 32'd0);
    chk("rst_rd0",  b.rd_data0, 32'h0);
    #20 reset_n = 1'b1;
    tick();

    // basic write, both ports same address
    b.rd_addr0 = 4'd3;
    b.rd_addr1 = 4'd3;
    wr16(4'd3, 32'hDEADBEEF, 4'hF);
    chk("wr_full_p0", b.rd_data0, 32'hDEADBEEF);
    chk("wr_full_p1", b.rd_data1, 32'hDEADBEEF);

    wr16(4'd3, 32'h11223344, 4'b0101);
    chk("wr_be_0101", b.rd_data0, 32'hDE22BE44);
    wr16(4'd3, 32'h00000000, 4'b0000);
    chk("wr_be_zero", b.rd_data1, 32'hDE22BE44);

    // write/read overlap on entry 7
    wr16(4'd7, 32'h01020304, 4'hF);
    b.rd_addr0 = 4'd7;
    b.wr_en = 1'b1;  b.wr_addr = 4'd7;  b.wr_data = 32'hA5A5A5A5;  b.wr_be = 4'hF;
    #1;
`ifdef REGFILE_WR_BYPASS_EN
    chk("bypass_same_cycle", b.rd_data0, 32'hA5A5A5A5);
`else
    chk("no_bypass_same_cycle", b.rd_data0, 32'h01020304);
`endif
    tick();
    b.wr_en = 1'b0;  b.wr_be = '0;
    chk("after_edge_e7", b.rd_data0, 32'hA5A5A5A5);

    // DEPTH=12 range checks
    b12.wr_en = 1'b1;  b12.wr_addr = 4'd11;  b12.wr_data = 32'hCAFE0011;  b12.wr_be = 4'hF;
    tick();
    b12.wr_addr = 4'd13;  b12.wr_data = 32'hBAD00BAD;
    tick();
    b12.wr_en = 1'b0;
    b12.rd_addr0 = 4'd13;  b12.rd_addr1 = 4'd11;
    #1;
    chk("d12_rd13", b12.rd_data0, 32'h0);
    chk("d12_rd11", b12.rd_data1, 32'hCAFE0011);
    b12.rd_addr0 = 4'd1;
    #1;
    chk("d12_rd1", b12.rd_data0, 32'h0);
    b12.rd_addr0 = 4'd12;
    #1;
    chk("d12_rd12", b12.rd_data0, 32'h0);

    // fill all entries
    for (int i = 0; i < 16; i++) wr16(4'(i), fillv(i), 4'hF);
    b.rd_addr0 = 4'd5;  b.rd_addr1 = 4'd15;
    #1;
    chk("fill_e5",  b.rd_data0, fillv(5));
    chk("fill_e15", b.rd_data1, fillv(15));

    // clear started together with a write to entry 2
    b.clr_req = 1'b1;
    b.wr_en = 1'b1;  b.wr_addr = 4'd2;  b.wr_data = 32'hFFFFFFFF;  b.wr_be = 4'hF;
    tick();
    b.wr_en = 1'b0;  b.wr_be = '0;
    b.rd_addr0 = 4'd2;  b.rd_addr1 = 4'd3;
    #1;
    chk("clr_start_busy", 32'(b.clr_busy), 32'd1);
    chk("clr_start_wr_e2", b.rd_data0, 32'hFFFFFFFF);
    busy_cycles = 0;
    done_cycles = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (b.clr_busy) busy_cycles++;
      if (b.clr_done) done_cycles++;
      if (cyc == 3) begin
        chk("mid_clr_swept_e2", b.rd_data0, 32'h0);
        chk("mid_clr_old_e3",   b.rd_data1, fillv(3));
      end
      if (cyc == 2)  b.clr_req = 1'b0;
      if (cyc == 9)  b.clr_req = 1'b1;
      if (cyc == 10) b.clr_req = 1'b0;
      if (cyc == 4) begin
        b.wr_en = 1'b1;  b.wr_addr = 4'd1;  b.wr_data = 32'h12345678;  b.wr_be = 4'hF;
      end
      if (cyc == 5) begin
        b.wr_en = 1'b0;  b.wr_be = '0;
      end
      tick();
    end
    chk("clr_busy_cycles", 32'(busy_cycles), 32'd16);
    chk("clr_done_cycles", 32'(done_cycles), 32'd1);
    chk("clr_end_busy", 32'(b.clr_busy), 32'd0);
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      b.rd_addr0 = 4'(i);
      b.rd_addr1 = 4'(15 - i);
      #1;
      acc = acc | b.rd_data0 | b.rd_data1;
    end
    chk("clr_all_zero", acc, 32'h0);

    // reset during a clear
    wr16(4'd9, 32'h00000099, 4'hF);
    b.rd_addr0 = 4'd9;
    b.clr_req = 1'b1;
    tick();
    b.clr_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_busy", 32'(b.clr_busy), 32'd1);
    chk("pre_rst_e9",   b.rd_data0, 32'h00000099);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(b.clr_busy), 32'd0);
    chk("rst_mid_done", 32'(b.clr_done), 32'd0);
    chk("rst_mid_e9",   b.rd_data0, 32'h0);
    #12 reset_n = 1'b1;
    busy_cycles = 0;
    done_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b.clr_busy) busy_cycles++;
      if (b.clr_done) done_cycles++;
    end
    chk("post_rst_busy", 32'(busy_cycles), 32'd0);
    chk("post_rst_done", 32'(done_cycles), 32'd0);
    b.clr_req = 1'b1;
    tick();
    b.clr_req = 1'b0;
    chk("post_rst_restart", 32'(b.clr_busy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 Parameter DATA_W, default 32: entry width in bits; SHALL be a multiple of 8, range 8..128.
REQ-002 Parameter DEPTH, default 16: number of entries, range 2..256; need not be a power of two.
REQ-003 Parameter ADDR_W, default 4: address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 wr_en  in  1  write request for the current cycle.
REQ-007 wr_addr  in  ADDR_W  write entry index.
REQ-008 wr_data  in  DATA_W  write data.
REQ-009 wr_be  in  DATA_W/8  byte enables; bit k covers wr_data[8k+7:8k].
REQ-010 rd_addr0 / rd_addr1  in  ADDR_W  independent read indices, ports 0 and 1.
REQ-011 rd_data0 / rd_data1  out  DATA_W  combinational read data, ports 0 and 1.
REQ-012 clr_req  in  1  request to start a sequential clear of all entries.
REQ-013 clr_busy  out  1  high while the clear sequence runs.
REQ-014 clr_done  out  1  single-cycle pulse when the clear sequence completes.

Function
REQ-015 Write: on a rising edge with wr_en=1, clr_busy=0, wr_addr<DEPTH, the bytes of entry wr_addr selected by wr_be SHALL take wr_data; unselected bytes SHALL hold.
REQ-016 A write with wr_be all zero, wr_addr>=DEPTH, or clr_busy=1 SHALL change no entry.
REQ-017 Read: rd_dataN SHALL equal the stored entry rd_addrN with zero cycles of latency; rd_addrN>=DEPTH SHALL return all zeros.
REQ-018 Both read ports SHALL operate concurrently, including when they use the same address.
REQ-019 Clear FSM states: IDLE and CLEAR; there SHALL be exactly one internal clear pointer of ADDR_W bits.
REQ-020 IDLE->CLEAR on an edge with clr_req=1; the pointer SHALL load 0 and clr_busy SHALL rise after that edge.
REQ-021 In CLEAR, each edge SHALL zero the entry at the pointer and increment the pointer; the clear SHALL take exactly DEPTH cycles.
REQ-022 The edge that clears entry DEPTH-1 SHALL return the FSM to IDLE, drop clr_busy, and raise clr_done for exactly one cycle.
REQ-023 In CLEAR, clr_req SHALL be ignored; it SHALL neither restart nor extend the sequence.
REQ-024 When clr_req=1 and wr_en=1 on the same IDLE edge, the write SHALL complete and the clear SHALL start on that edge; the written entry SHALL later be zeroed by the sweep.
REQ-025 Reads during CLEAR SHALL return current contents: zero for entries already swept, old data for entries not yet swept.

Reset
REQ-026 reset_n low SHALL immediately and asynchronously zero all entries, force IDLE, zero the pointer, and drive clr_busy=0 and clr_done=0, whatever the FSM state.
REQ-027 Reset asserted mid-clear SHALL abort the sequence without a clr_done pulse; after release the block SHALL be in IDLE.

Configuration
REQ-028 Macro REGFILE_WR_BYPASS_EN: when defined, if wr_en=1, the write is accepted per REQ-015, and rd_addrN==wr_addr, rd_dataN SHALL show the byte-merged write result combinationally in the same cycle.
REQ-029 Without REGFILE_WR_BYPASS_EN, rd_dataN SHALL show the pre-write contents until after the edge; there SHALL be no wr_data to rd_data combinational path.

Verification
REQ-030 Reset, then write 0xDEADBEEF to entry 3 with wr_be=4'hF; read it on both ports the next cycle -> rd_data0 = rd_data1 = 0xDEADBEEF.
REQ-031 Entry 3 holds 0xDEADBEEF; write 0x11223344 with wr_be=4'b0101 -> entry 3 = 0xDE22BE44.
REQ-032 DEPTH=12: write to address 13 -> no entry changes; reading address 13 -> 0x00000000.
REQ-033 Fill all entries, then pulse clr_req -> clr_busy high for 16 cycles, clr_done high for 1 cycle, all reads return 0; a write during busy is dropped.
REQ-034 Assert reset_n low at cycle 5 of a clear -> all outputs 0 immediately, no clr_done pulse, and IDLE after release.
REQ-035 With REGFILE_WR_BYPASS_EN defined, write 0xA5A5A5A5 to entry 7 while rd_addr0=7 -> rd_data0 = 0xA5A5A5A5 in the same cycle; without the macro, rd_data0 shows the old value until after the edge.
